// File: rtl/board_io_pkg.sv
// Shared types for the board IO conditioner; the LED mode encoding is also
// used by the software-facing register definitions.
package board_io_pkg;

   typedef enum logic [1:0] {
      LED_OFF       = 2'b00,
      LED_DIRECT    = 2'b01,
      LED_ACTIVITY  = 2'b10,
      LED_HEARTBEAT = 2'b11
   } led_mode_e;

endpackage

// File: rtl/board_io_debounce.sv
// One-bit two-flop synchroniser plus debouncer. Edge pulses are built only
// when BOARD_IO_EDGE_DETECT_EN is defined; otherwise rise_o/fall_o are tied low.
module board_io_debounce #(
   parameter int unsigned DebounceCycles = 1000
) (
   input  logic clk_sys_i,
   input  logic rst_sys_i,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CntW = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            update;

   // A change is accepted only after sync2 has disagreed with the stable
   // value for DebounceCycles consecutive cycles; any agreement restarts the count.
   always_comb begin
      update   = (sync2_q != stable_q) && (cnt_q == CntLast);
      cnt_d    = '0;
      stable_d = stable_q;
      if (update) begin
         stable_d = sync2_q;
      end else if (sync2_q != stable_q) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

`ifdef BOARD_IO_EDGE_DETECT_EN
   logic rise_q, fall_q;

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= update & sync2_q;
         fall_q <= update & ~sync2_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/board_io_ctrl.sv
// Board IO conditioner: debounced GPIs, heartbeat, and per-LED mode mux with
// activity stretching. Edge pulses depend on BOARD_IO_EDGE_DETECT_EN.
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int unsigned GpiWidth       = 5,
   parameter int unsigned LedWidth       = 3,
   parameter int unsigned HeartbeatWidth = 25,
   parameter int unsigned DebounceCycles = 1000,
   parameter int unsigned StretchCycles  = 1_000_000
) (
   input  logic                  clk_sys_i,
   input  logic                  rst_sys_i,
   input  logic [GpiWidth-1:0]   gpi_raw_i,
   output logic [GpiWidth-1:0]   gpi_o,
   output logic [GpiWidth-1:0]   gpi_rise_o,
   output logic [GpiWidth-1:0]   gpi_fall_o,
   input  logic [2*LedWidth-1:0] led_mode_i,
   input  logic [LedWidth-1:0]   led_direct_i,
   input  logic [LedWidth-1:0]   activity_i,
   output logic [LedWidth-1:0]   led_o,
   output logic                  heartbeat_o
);

   localparam int unsigned StretchW = (StretchCycles > 1) ? $clog2(StretchCycles) : 1;
   localparam logic [StretchW-1:0] StretchLoad = StretchW'(StretchCycles - 1);

   for (genvar g = 0; g < GpiWidth; g++) begin : gen_gpi
      board_io_debounce #(
         .DebounceCycles(DebounceCycles)
      ) u_debounce (
         .clk_sys_i(clk_sys_i),
         .rst_sys_i(rst_sys_i),
         .raw_i    (gpi_raw_i[g]),
         .stable_o (gpi_o[g]),
         .rise_o   (gpi_rise_o[g]),
         .fall_o   (gpi_fall_o[g])
      );
   end

   logic [HeartbeatWidth-1:0]          hb_q;
   logic [LedWidth-1:0][StretchW-1:0]  scnt_q, scnt_d;
   logic [LedWidth-1:0]                stretched;
   logic [LedWidth-1:0]                led_q, led_d;

   // Stretchers and heartbeat run in every mode so switching into ACTIVITY or
   // HEARTBEAT shows the current state immediately.
   always_comb begin
      scnt_d    = scnt_q;
      stretched = '0;
      led_d     = '0;
      for (int i = 0; i < LedWidth; i++) begin
         if (activity_i[i]) begin
            scnt_d[i] = StretchLoad;
         end else if (scnt_q[i] != '0) begin
            scnt_d[i] = scnt_q[i] - StretchW'(1);
         end
         stretched[i] = activity_i[i] | (scnt_q[i] != '0);
         case (led_mode_e'(led_mode_i[2*i +: 2]))
            LED_OFF:       led_d[i] = 1'b0;
            LED_DIRECT:    led_d[i] = led_direct_i[i];
            LED_ACTIVITY:  led_d[i] = stretched[i];
            LED_HEARTBEAT: led_d[i] = hb_q[HeartbeatWidth-1];
            default:       led_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         hb_q   <= '0;
         scnt_q <= '0;
         led_q  <= '0;
      end else begin
         hb_q   <= hb_q + HeartbeatWidth'(1);
         scnt_q <= scnt_d;
         led_q  <= led_d;
      end
   end

   assign led_o       = led_q;
   assign heartbeat_o = hb_q[HeartbeatWidth-1];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl against a sliding-window / elapsed-time
// model; expected edge pulses follow BOARD_IO_EDGE_DETECT_EN.
module tb_board_io_ctrl;
   import board_io_pkg::*;

   localparam int GW = 5;
   localparam int LW = 3;
   localparam int HW = 4;
   localparam int DC = 4;
   localparam int SC = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [GW-1:0]   gpiRaw, gpiO, riseO, fallO;
   logic [2*LW-1:0] ledMode;
   logic [LW-1:0]   ledDirect, activity, ledO;
   logic            hbO;

`ifdef BOARD_IO_EDGE_DETECT_EN
   localparam bit EdgeOn = 1'b1;
`else
   localparam bit EdgeOn = 1'b0;
`endif

   board_io_ctrl #(
      .GpiWidth      (GW),
      .LedWidth      (LW),
      .HeartbeatWidth(HW),
      .DebounceCycles(DC),
      .StretchCycles (SC)
   ) dut (
      .clk_sys_i   (clk),
      .rst_sys_i   (rst),
      .gpi_raw_i   (gpiRaw),
      .gpi_o       (gpiO),
      .gpi_rise_o  (riseO),
      .gpi_fall_o  (fallO),
      .led_mode_i  (ledMode),
      .led_direct_i(ledDirect),
      .activity_i  (activity),
      .led_o       (ledO),
      .heartbeat_o (hbO)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Model: raw samples pass through a 2-deep history; a debounced bit flips when
   // the DC most recent synchronised samples all disagree with it.
   logic [GW-1:0] hist [DC+2];
   logic [GW-1:0] mStable, mRise, mFall;
   logic [LW-1:0] mLed;
   logic          mHb;
   int            edgeNo;
   int            lastAct [LW];
   bit            modelValid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < DC + 2; j++) hist[j] = '0;
         mStable = '0; mRise = '0; mFall = '0; mLed = '0; mHb = 1'b0;
         edgeNo = 0;
         for (int i = 0; i < LW; i++) lastAct[i] = -1000;
         modelValid = 1'b1;
      end else begin
         for (int i = 0; i < LW; i++) begin
            logic str;
            str = activity[i] || ((edgeNo - lastAct[i]) < SC);
            case (ledMode[2*i +: 2])
               2'b00:   mLed[i] = 1'b0;
               2'b01:   mLed[i] = ledDirect[i];
               2'b10:   mLed[i] = str;
               default: mLed[i] = mHb;
            endcase
            if (activity[i]) lastAct[i] = edgeNo;
         end
         edgeNo++;
         mHb = (edgeNo % (1 << HW)) >= (1 << (HW - 1));
         for (int j = DC + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = gpiRaw;
         mRise = '0; mFall = '0;
         for (int b = 0; b < GW; b++) begin
            bit allDiff;
            allDiff = 1'b1;
            for (int j = 2; j < DC + 2; j++) if (hist[j][b] == mStable[b]) allDiff = 1'b0;
            if (allDiff) begin
               mRise[b]   = ~mStable[b];
               mFall[b]   = mStable[b];
               mStable[b] = ~mStable[b];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("gpi_o", 32'(gpiO), 32'(mStable));
         checkOutput("gpi_rise_o", 32'(riseO), EdgeOn ? 32'(mRise) : 32'd0);
         checkOutput("gpi_fall_o", 32'(fallO), EdgeOn ? 32'(mFall) : 32'd0);
         checkOutput("led_o", 32'(ledO), 32'(mLed));
         checkOutput("heartbeat_o", 32'(hbO), 32'(mHb));
      end
   end

   task automatic applyStimulus(input logic [GW-1:0] raw, input logic [2*LW-1:0] mode,
                                input logic [LW-1:0] direct, input logic [LW-1:0] act,
                                input int cycles);
      gpiRaw    = raw;
      ledMode   = mode;
      ledDirect = direct;
      activity  = act;
      repeat (cycles) @(negedge clk);
   endtask

   // Counts cycles until the selected signal changes; bounded so it cannot hang.
   task automatic waitToggle(input bit useLed, output int cycles);
      logic prev;
      prev = useLed ? ledO[0] : hbO;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (((useLed ? ledO[0] : hbO) == prev) && cycles < 40);
   endtask

   int cnt, lat, pulses;

   initial begin
      rst = 1'b1;
      applyStimulus(5'h1F, '0, '0, '0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset gpi_o", 32'(gpiO), 32'h0);
      checkOutput("reset led_o", 32'(ledO), 32'h0);
      checkOutput("reset heartbeat_o", 32'(hbO), 32'h0);
      checkOutput("reset pulses", 32'(riseO | fallO), 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("release gpi_o edge 5", 32'(gpiO), 32'h0);
      @(negedge clk);
      checkOutput("release gpi_o edge 6", 32'(gpiO), 32'h1F);

      // Glitch rejection on bit0
      applyStimulus(5'h00, '0, '0, '0, 12);
      checkOutput("settle low", 32'(gpiO), 32'h0);
      pulses = 0;
      applyStimulus(5'h01, '0, '0, '0, 1); pulses += riseO[0];
      applyStimulus(5'h01, '0, '0, '0, 1); pulses += riseO[0];
      applyStimulus(5'h01, '0, '0, '0, 1); pulses += riseO[0];
      for (int c = 0; c < 10; c++) begin
         applyStimulus(5'h00, '0, '0, '0, 1);
         pulses += riseO[0];
      end
      checkOutput("glitch gpi_o[0]", 32'(gpiO[0]), 32'h0);
      checkOutput("glitch rise count", 32'(pulses), 32'h0);

      lat = 0; pulses = 0;
      gpiRaw = 5'h01;
      for (int c = 0; c < 20 && lat == 0; c++) begin
         @(negedge clk);
         pulses += riseO[0];
         if (gpiO[0]) lat = c + 1;
      end
      checkOutput("held latency", 32'(lat), 32'd6);
      repeat (6) begin @(negedge clk); pulses += riseO[0]; end
      checkOutput("held rise count", 32'(pulses), EdgeOn ? 32'd1 : 32'd0);

      // Reset in mid-debounce discards the pending change
      applyStimulus(5'h03, '0, '0, '0, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(5'h00, '0, '0, '0, 8);
      checkOutput("mid-debounce reset", 32'(gpiO), 32'h0);

      // Heartbeat on LED0
      applyStimulus(5'h00, 6'b00_00_11, '0, '0, 1);
      waitToggle(1'b0, cnt);
      waitToggle(1'b0, cnt);
      checkOutput("heartbeat half period", 32'(cnt), 32'd8);
      waitToggle(1'b1, cnt);
      waitToggle(1'b1, cnt);
      checkOutput("led0 heartbeat half period", 32'(cnt), 32'd8);

      // Activity stretch on LED1
      applyStimulus(5'h00, 6'b00_10_00, '0, '0, 4);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(5'h00, 6'b00_10_00, '0, (c == 0) ? 3'b010 : 3'b000, 1);
         cnt += ledO[1];
      end
      checkOutput("stretch length", 32'(cnt), 32'd8);
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         applyStimulus(5'h00, 6'b00_10_00, '0, (c == 0 || c == 5) ? 3'b010 : 3'b000, 1);
         cnt += ledO[1];
      end
      checkOutput("retrigger length", 32'(cnt), 32'd13);

      // Direct and off on LED2
      applyStimulus(5'h00, 6'b01_00_00, 3'b100, '0, 1);
      checkOutput("direct high", 32'(ledO[2]), 32'h1);
      applyStimulus(5'h00, 6'b01_00_00, 3'b000, '0, 1);
      checkOutput("direct low", 32'(ledO[2]), 32'h0);
      applyStimulus(5'h00, 6'b01_00_00, 3'b100, '0, 1);
      checkOutput("direct high again", 32'(ledO[2]), 32'h1);
      applyStimulus(5'h00, 6'b00_00_00, 3'b100, '0, 1);
      checkOutput("off", 32'(ledO[2]), 32'h0);

      // Pseudo-random slow toggling, checked cycle by cycle by the model
      pulses = 0;
      for (int c = 0; c < 50; c++) begin
         logic [GW-1:0] r;
         r = gpiRaw;
         if ($urandom_range(0, 5) == 0) r = 5'($urandom);
         applyStimulus(r, 6'($urandom), 3'($urandom), 3'($urandom), 1);
         pulses += $countones(riseO) + $countones(fallO);
      end
      applyStimulus(5'h00, '0, '0, '0, 10);
      checkOutput("random settle", 32'(gpiO), 32'h0);
      if (!EdgeOn) checkOutput("pulses tied off", 32'(pulses), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
